// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the CPU data path and the
// video fetch engine; each access runs IDLE -> ISSUE -> (WAIT) -> RESP.
module mem_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_ren,
    input  logic                  cpu_wen,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    input  logic [DATA_W/8-1:0]   cpu_wstrb,
    output logic                  cpu_ready,
    output logic [DATA_W-1:0]     cpu_rdata,
    input  logic                  vid_req,
    input  logic [ADDR_W-1:0]     vid_addr,
    output logic                  vid_ready,
    output logic [DATA_W-1:0]     vid_rdata,
    output logic                  mem_en,
    output logic [DATA_W/8-1:0]   mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy
);
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;
    typedef enum logic {PORT_CPU, PORT_VID} port_e;

    state_e              state_q, state_d;
    port_e               last_q, last_d;
    port_e               grant_q, grant_d;
    logic                write_q, write_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                mem_en_q, mem_en_d;
    logic [STRB_W-1:0]   mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                cpu_ready_q, cpu_ready_d;
    logic                vid_ready_q, vid_ready_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   vid_rdata_q, vid_rdata_d;
    logic                busy_q, busy_d;
    logic                cpu_req;

    assign cpu_req = cpu_ren | cpu_wen;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        grant_d     = grant_q;
        write_d     = write_q;
        cnt_d       = cnt_q;
        mem_en_d    = 1'b0;
        mem_we_d    = '0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        vid_rdata_d = vid_rdata_q;

        case (state_q)
            S_IDLE: begin
                // Memory-port outputs are registered, so the command is loaded
                // on the grant edge and appears exactly in the ISSUE cycle.
                if (cpu_req || vid_req) begin
                    grant_d  = (cpu_req && (!vid_req || last_q == PORT_VID)) ? PORT_CPU : PORT_VID;
                    last_d   = grant_d;
                    state_d  = S_ISSUE;
                    mem_en_d = 1'b1;
                    if (grant_d == PORT_CPU) begin
                        write_d     = cpu_wen;
                        mem_addr_d  = cpu_addr;
                        mem_wdata_d = cpu_wdata;
                        mem_we_d    = cpu_wen ? cpu_wstrb : '0;
                    end else begin
                        write_d    = 1'b0;
                        mem_addr_d = vid_addr;
                    end
                end
            end
            S_ISSUE: begin
                if (write_q) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d   = 3'(READ_LATENCY);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = S_RESP;
                    if (grant_q == PORT_CPU) cpu_rdata_d = mem_rdata;
                    else                     vid_rdata_d = mem_rdata;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
        endcase

        cpu_ready_d = (state_d == S_RESP) && (grant_q == PORT_CPU);
        vid_ready_d = (state_d == S_RESP) && (grant_q == PORT_VID);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            last_q      <= PORT_VID;
            grant_q     <= PORT_CPU;
            write_q     <= 1'b0;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_ready_q <= 1'b0;
            vid_ready_q <= 1'b0;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            write_q     <= write_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_ready_q <= cpu_ready_d;
            vid_ready_q <= vid_ready_d;
            cpu_rdata_q <= cpu_rdata_d;
            vid_rdata_q <= vid_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_ready = cpu_ready_q;
    assign vid_ready = vid_ready_q;
    assign cpu_rdata = cpu_rdata_q;
    assign vid_rdata = vid_rdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter at READ_LATENCY=2: directed requests push
// expected memory strobes and ready responses; negedge monitors pop and compare.
module tb_mem_arbiter;
    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_ren, cpu_wen;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        vid_req;
    logic [31:0] vid_addr;
    logic        vid_ready;
    logic [31:0] vid_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        busy;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .cpu_ren(cpu_ren), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .vid_req(vid_req), .vid_addr(vid_addr),
        .vid_ready(vid_ready), .vid_rdata(vid_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit vid; logic [31:0] data; int unsigned cyc; } resp_t;
    typedef struct { logic [3:0] we; logic [31:0] addr; logic [31:0] wdata; int unsigned cyc; } memx_t;
    resp_t resp_q[$];
    memx_t memx_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : {16'hC0DE, a[15:0]};
    endfunction

    // Memory macro model: read data is valid only LAT cycles after the strobe.
    bit          pend = 0;
    int unsigned pend_due = 0;
    logic [31:0] pend_data = 32'h0;
    always @(negedge clk) begin
        if (pend && cyc == pend_due) begin
            mem_rdata = pend_data;
            pend = 0;
        end else begin
            mem_rdata = 32'hBAD00000 | 32'(cyc[15:0]);
        end
        if (mem_en && mem_we == 4'h0) begin
            pend      = 1;
            pend_due  = cyc + LAT;
            pend_data = mem_word(mem_addr);
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (cpu_ready || vid_ready) begin
                if (resp_q.size() == 0) begin
                    chk("spurious_ready", {30'd0, vid_ready, cpu_ready}, 32'd0);
                end else begin
                    resp_t r;
                    r = resp_q.pop_front();
                    chk("ready_port", {30'd0, vid_ready, cpu_ready}, r.vid ? 32'd2 : 32'd1);
                    chk("ready_cycle", 32'(cyc), 32'(r.cyc));
                    chk(r.vid ? "vid_rdata" : "cpu_rdata", r.vid ? vid_rdata : cpu_rdata, r.data);
                end
            end
            if (mem_en) begin
                if (memx_q.size() == 0) begin
                    chk("spurious_mem_en", 32'(mem_en), 32'd0);
                end else begin
                    memx_t m;
                    m = memx_q.pop_front();
                    chk("mem_en_cycle", 32'(cyc), 32'(m.cyc));
                    chk("mem_we", 32'(mem_we), 32'(m.we));
                    chk("mem_addr", mem_addr, m.addr);
                    if (m.we != 4'h0) chk("mem_wdata", mem_wdata, m.wdata);
                end
            end else begin
                chk("idle_mem_we", 32'(mem_we), 32'd0);
            end
        end
    end

    task automatic wait_ready(input bit vid, input int unsigned budget);
        bit seen = 0;
        for (int unsigned i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = vid ? vid_ready : cpu_ready;
        end
        chk("ready_timeout", 32'(seen), 32'd1);
    endtask

    task automatic wait_n_ready(input int unsigned n, input int unsigned budget);
        int unsigned got = 0;
        for (int unsigned i = 0; i < budget && got < n; i++) begin
            @(negedge clk);
            if (cpu_ready || vid_ready) got++;
        end
        chk("ready_count_timeout", 32'(got), 32'(n));
    endtask

    task automatic exp_mem(input logic [3:0] we, input logic [31:0] a, input logic [31:0] wd, input int unsigned c);
        memx_t m;
        m.we = we; m.addr = a; m.wdata = wd; m.cyc = c;
        memx_q.push_back(m);
    endtask

    task automatic exp_resp(input bit vid, input logic [31:0] d, input int unsigned c);
        resp_t r;
        r.vid = vid; r.data = d; r.cyc = c;
        resp_q.push_back(r);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int unsigned c0;

    initial begin
        reset = 1; cpu_ren = 0; cpu_wen = 0; cpu_addr = 0; cpu_wdata = 0;
        cpu_wstrb = 0; vid_req = 0; vid_addr = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_ready", {30'd0, vid_ready, cpu_ready}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        reset = 0;

        // CPU read, ready at cycle LAT+2
        @(negedge clk); c0 = cyc;
        cpu_ren = 1; cpu_addr = 32'h100;
        exp_mem(4'h0, 32'h100, 32'h0, c0 + 1);
        exp_resp(0, 32'hDEADBEEF, c0 + 4);
        wait_ready(0, 20); cpu_ren = 0;

        // CPU write, rdata must hold
        @(negedge clk); c0 = cyc;
        cpu_wen = 1; cpu_addr = 32'h200; cpu_wdata = 32'h12345678; cpu_wstrb = 4'b0011;
        exp_mem(4'b0011, 32'h200, 32'h12345678, c0 + 1);
        exp_resp(0, 32'hDEADBEEF, c0 + 2);
        wait_ready(0, 20); cpu_wen = 0;

        // Tie right after reset: CPU, VID, CPU, VID
        @(negedge clk); reset = 1;
        @(negedge clk); reset = 0; c0 = cyc;
        cpu_ren = 1; cpu_addr = 32'h300; vid_req = 1; vid_addr = 32'h40;
        exp_mem(4'h0, 32'h300, 32'h0, c0 + 1);
        exp_mem(4'h0, 32'h040, 32'h0, c0 + 6);
        exp_mem(4'h0, 32'h300, 32'h0, c0 + 11);
        exp_mem(4'h0, 32'h040, 32'h0, c0 + 16);
        exp_resp(0, 32'hC0DE0300, c0 + 4);
        exp_resp(1, 32'hC0DE0040, c0 + 9);
        exp_resp(0, 32'hC0DE0300, c0 + 14);
        exp_resp(1, 32'hC0DE0040, c0 + 19);
        wait_n_ready(4, 60);
        cpu_ren = 0; vid_req = 0;

        // Video stream, 4 reads spaced LAT+3 apart
        @(negedge clk); c0 = cyc;
        vid_req = 1; vid_addr = 32'h0;
        for (int unsigned k = 0; k < 4; k++) begin
            exp_mem(4'h0, 32'(4 * k), 32'h0, c0 + 1 + 5 * k);
            exp_resp(1, 32'hC0DE0000 | 32'(4 * k), c0 + 4 + 5 * k);
        end
        for (int unsigned k = 0; k < 4; k++) begin
            wait_ready(1, 20);
            vid_addr = 32'(4 * (k + 1));
        end
        vid_req = 0;

        // Reset during WAIT discards the read; tie afterwards goes to CPU
        @(negedge clk); c0 = cyc;
        cpu_ren = 1; cpu_addr = 32'h500;
        exp_mem(4'h0, 32'h500, 32'h0, c0 + 1);
        @(negedge clk);
        @(negedge clk); reset = 1; cpu_ren = 0;
        @(negedge clk); reset = 0;
        chk("wait_rst_busy", 32'(busy), 32'd0);
        chk("wait_rst_mem_en", 32'(mem_en), 32'd0);
        chk("wait_rst_ready", {30'd0, vid_ready, cpu_ready}, 32'd0);
        chk("wait_rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("wait_rst_vid_rdata", vid_rdata, 32'd0);
        c0 = cyc;
        cpu_ren = 1; cpu_addr = 32'h100; vid_req = 1; vid_addr = 32'h44;
        exp_mem(4'h0, 32'h100, 32'h0, c0 + 1);
        exp_mem(4'h0, 32'h044, 32'h0, c0 + 6);
        exp_resp(0, 32'hDEADBEEF, c0 + 4);
        exp_resp(1, 32'hC0DE0044, c0 + 9);
        wait_ready(0, 20); cpu_ren = 0;
        wait_ready(1, 20); vid_req = 0;

        // ren and wen together behave as a write
        @(negedge clk); c0 = cyc;
        cpu_ren = 1; cpu_wen = 1; cpu_addr = 32'h600; cpu_wdata = 32'hCAFEF00D; cpu_wstrb = 4'hF;
        exp_mem(4'hF, 32'h600, 32'hCAFEF00D, c0 + 1);
        exp_resp(0, 32'hDEADBEEF, c0 + 2);
        wait_ready(0, 20); cpu_ren = 0; cpu_wen = 0;

        repeat (8) @(negedge clk);
        chk("resp_queue_drained", 32'(resp_q.size()), 32'd0);
        chk("mem_queue_drained", 32'(memx_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory port between two requesters: the CPU data path (the mem_ren/mem_wen side of the address decoder) and the HDMI video fetch engine.
- Arbitrates round-robin, sequences each access with a fixed memory read latency, and returns a one-cycle ready pulse with registered read data to the winning requester.
- Sits between the address decoder / video fetcher and the memory macro.

Parameters:
- ADDR_W, 32, address width, byte address passed through unchanged.
- DATA_W, 32, data width; write strobe width is DATA_W/8.
- READ_LATENCY, 1, cycles from the mem_en cycle to valid mem_rdata; legal range 1..4.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- cpu_ren  input  1  CPU read request, level, held until cpu_ready
- cpu_wen  input  1  CPU write request, level, held until cpu_ready
- cpu_addr  input  ADDR_W  CPU address, stable while requesting
- cpu_wdata  input  DATA_W  CPU write data
- cpu_wstrb  input  DATA_W/8  CPU byte enables
- cpu_ready  output  1  one-cycle completion pulse
- cpu_rdata  output  DATA_W  CPU read data, valid with cpu_ready, held afterwards
- vid_req  input  1  video read request, level, held until vid_ready
- vid_addr  input  ADDR_W  video address
- vid_ready  output  1  one-cycle completion pulse
- vid_rdata  output  DATA_W  video read data, valid with vid_ready, held afterwards
- mem_en  output  1  memory access strobe, one cycle per transaction
- mem_we  output  DATA_W/8  memory byte write enables; zero for reads
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset: all outputs are 0, state goes to IDLE, last_grant goes to VID, and the wait counter is 0.
  - An in-flight transaction is discarded with no ready pulse; requesters re-issue it.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: samples the requests each cycle. The CPU request is cpu_ren|cpu_wen.
  - One request only: grant it.
  - Both requests: grant the port that is not last_grant.
  - On grant, register the granted port, address, wdata and wstrb; set last_grant; go to ISSUE.
- ISSUE (exactly one cycle): mem_en=1, mem_addr and mem_wdata come from the registered command.
  - Write: mem_we = wstrb, next state RESP.
  - Read: mem_we = 0, counter loads READ_LATENCY, next state WAIT.
- WAIT: the counter decrements each cycle.
  - In the cycle mem_rdata is valid (READ_LATENCY cycles after ISSUE), capture it into the granted port's rdata register.
  - Then go to RESP.
- RESP (one cycle): the granted port's ready is 1; then go to IDLE.
- Latency, counted with the request sampled in IDLE at cycle 0:
  - Write: mem_en at cycle 1, ready at cycle 2.
  - Read: mem_en at cycle 1, ready at cycle READ_LATENCY+2.
- Request in the cycle after ready: IDLE treats a request still high then as a new transaction.
  - Minimum spacing is 3 cycles per write and READ_LATENCY+3 per read.
- cpu_ren and cpu_wen both high: treated as a write.
- Data hold rules:
  - Writes never change cpu_rdata.
  - A port's rdata changes only on that port's read completion.
  - The non-granted port's ready stays 0.
- Outside ISSUE: mem_en=0 and mem_we=0. mem_addr and mem_wdata keep their last values.
- Request dropped after grant (protocol violation): the transaction still completes and the ready pulse is still issued.
- Fairness: under continuous dual requests, grants strictly alternate, so neither port waits more than one foreign transaction.

Test Plan:
1. CPU read only: READ_LATENCY=2, cpu_addr=0x100, mem_rdata=0xDEADBEEF when valid. Required:
   - mem_en high only at cycle 1, mem_we=0.
   - cpu_ready at cycle 4 with cpu_rdata=0xDEADBEEF.
   - vid_ready stays 0.
2. CPU write: cpu_addr=0x200, wdata=0x12345678, wstrb=0011. Required:
   - Cycle 1: mem_en=1, mem_we=0011, mem_addr=0x200.
   - Cycle 2: cpu_ready=1.
   - cpu_rdata is unchanged from its prior value.
3. Tie after reset: both requests rise together and are held continuously. Required:
   - Grant order is CPU, VID, CPU, VID.
   - Each ready pulses exactly once per transaction.
4. Video-only stream: vid_req held for 4 reads at addrs 0x0/0x4/0x8/0xC. Required:
   - 4 vid_ready pulses spaced READ_LATENCY+3 cycles apart.
   - vid_rdata matches each word.
5. Reset asserted during WAIT. Required:
   - Next cycle: busy=0, mem_en=0, both readies 0, both rdata=0.
   - A subsequent simultaneous request is granted to the CPU first.
6. cpu_ren=cpu_wen=1 with wstrb=1111. Required:
   - Handled as a write: mem_we=1111, ready after 2 cycles, no read capture.
